lpc_cycle_decoder: RTL and testbench
====================================

# lpc_cycle_decoder

Passive LPC bus cycle decoder clocked by the 33 MHz LPC-domain clock from the board PLL. It samples LAD[3:0] and LFRAME# every rising edge and reconstructs I/O and TPM read/write cycles. For each completed cycle it emits a one-cycle record strobe carrying address, data, direction and cycle kind to the capture/UART stage downstream. It never drives the bus.

## Interface
- SYNC_MAX, default 1023: maximum consecutive wait SYNC nibbles (0101/0110) tolerated before the cycle is dropped.
- lpc_clock  in  1  33 MHz LPC clock; all logic on its rising edge.
- lpc_reset  in  1  asynchronous, active-low reset (LRESET#); one clock domain only.
- lpc_frame  in  1  LFRAME#, active low.
- lpc_ad  in  4  LAD[3:0].
- out_valid  out  1  one-cycle pulse: record fields valid.
- out_addr  out  16  cycle address.
- out_data  out  8  data byte.
- out_dir  out  1  1 = write, 0 = read.
- out_tpm  out  1  1 = TPM cycle (START 0101), 0 = I/O cycle (START 0000).
- out_sync_err  out  1  1 = terminating SYNC was 1010 (error); data field then is 0x00 for reads.

## Operation
- States: IDLE, START, CYCDIR, ADDR, WDATA, TAR, SYNC, RDATA.
- Any state, lpc_frame==0: go to START; latch lpc_ad as start nibble. Takes priority over every other transition, including a cycle about to complete (that cycle is discarded, no out_valid).
- START, lpc_frame==1: the latched start nibble (value on the last LFRAME#-low cycle) is checked. 0000 → out_tpm candidate 0, 0101 → candidate 1; in both cases the current lpc_ad is the CYCTYPE+DIR nibble and is processed as CYCDIR in the same cycle. Any other start nibble → IDLE.
- CYCDIR: lpc_ad[3:2] must be 00 (I/O; used for TPM too), else IDLE (memory/DMA ignored). dir = lpc_ad[1]. Next ADDR.
- ADDR: 4 nibbles, most-significant first, shifted into addr[15:0]; 2-bit counter. Then WDATA if write, TAR if read.
- WDATA: 2 nibbles, least-significant first (data[3:0] then data[7:4]). Then TAR.
- TAR: exactly 2 cycles, contents ignored. Then SYNC.
- SYNC: 0000 → ready; 1010 → error; 0101/0110 → wait, increment wait counter; any other nibble → IDLE, no record. Wait counter reaching SYNC_MAX → IDLE, no record. Write: ready/error ends the cycle (emit record). Read: ready/error → RDATA.
- RDATA: 2 nibbles, LSN first; after second, emit record.
- Trailing TAR after a cycle is ignored (state IDLE).
- Wait counter: clog2(SYNC_MAX+1) bits, cleared on entry to SYNC, saturating.

## Timing
- Reset (lpc_reset==0, async): state IDLE, out_valid=0, out_addr=0, out_data=0, out_dir=0, out_tpm=0, out_sync_err=0, all internal counters/shift registers 0. Reset mid-frame drops the cycle with no record.
- All outputs registered. out_valid rises on the clock edge that samples the final required nibble (write: SYNC ready/error; read: second data nibble) and is high for exactly one cycle.
- out_addr/out_data/out_dir/out_tpm/out_sync_err update only together with out_valid and hold until the next record.
- Minimum write cycle: 1 START + 1 CYCDIR + 4 ADDR + 2 DATA + 2 TAR + 1 SYNC = 11 clocks; read 11 clocks. Back-to-back frames are accepted with zero idle cycles.
- Multiple LFRAME#-low cycles: start nibble is that of the last low cycle.

## Test plan
- I/O write 0x0080 ← 0x5A: LAD 0000(LFRAME# low), 0010, 0,0,8,0, A,5, F,F, 0000 → one out_valid, addr 0x0080, data 0x5A, dir 1, tpm 0, sync_err 0, 11 clocks after START.
- TPM read 0x0F00 = 0x81 with 3 long waits: 0101(low), 0000, 0,F,0,0, F,F, 0110×3, 0000, 1,8 → addr 0x0F00, data 0x81, dir 0, tpm 1.
- Abort: I/O write started, LFRAME# low after second address nibble, then full write to 0x002E ← 0x11 → exactly one record (0x002E/0x11).
- SYNC timeout with SYNC_MAX=4: 5 consecutive 0101 nibbles → no out_valid, state back in IDLE; following valid cycle decoded correctly.
- Memory cycle (CYCDIR 0100) and start nibble 1111 → no records; SYNC error 1010 on write → record with sync_err 1.
- Assert lpc_reset mid-ADDR → all outputs 0 immediately; no record; decoding resumes after release.

Source files
------------

// File: rtl/lpc_cycle_decoder.sv
// rtl/lpc_cycle_decoder.sv - passive LPC I/O and TPM cycle decoder emitting one record per completed cycle

module lpc_cycle_decoder #(
    parameter int SYNC_MAX = 1023
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        lpc_frame,
    input  logic [3:0]  lpc_ad,
    output logic        out_valid,
    output logic [15:0] out_addr,
    output logic [7:0]  out_data,
    output logic        out_dir,
    output logic        out_tpm,
    output logic        out_sync_err
);

    localparam int WW = (SYNC_MAX < 1) ? 1 : $clog2(SYNC_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(SYNC_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CYCDIR,
        S_ADDR,
        S_WDATA,
        S_TAR,
        S_SYNC,
        S_RDATA
    } state_t;

    state_t          state, state_d;
    logic [3:0]      start_nib, start_nib_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            dir_q, dir_d;
    logic            tpm_q, tpm_d;
    logic            err_q, err_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            emit;
    logic [7:0]      rec_data;

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state        <= S_IDLE;
            start_nib    <= 4'd0;
            addr_q       <= 16'd0;
            data_q       <= 8'd0;
            dir_q        <= 1'b0;
            tpm_q        <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 2'd0;
            wait_q       <= '0;
            out_valid    <= 1'b0;
            out_addr     <= 16'd0;
            out_data     <= 8'd0;
            out_dir      <= 1'b0;
            out_tpm      <= 1'b0;
            out_sync_err <= 1'b0;
        end else begin
            state     <= state_d;
            start_nib <= start_nib_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            tpm_q     <= tpm_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            out_valid <= emit;
            if (emit) begin
                out_addr     <= addr_q;
                out_data     <= rec_data;
                out_dir      <= dir_q;
                out_tpm      <= tpm_q;
                out_sync_err <= err_d;
            end
        end
    end

    // Read data reported as zero when the peripheral signalled a SYNC error
    assign rec_data = (err_d && !dir_q) ? 8'h00 : data_d;

    always_comb begin
        state_d     = state;
        start_nib_d = start_nib;
        addr_d      = addr_q;
        data_d      = data_q;
        dir_d       = dir_q;
        tpm_d       = tpm_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        emit        = 1'b0;

        if (!lpc_frame) begin
            state_d     = S_START;
            start_nib_d = lpc_ad;
        end else begin
            case (state)
                S_IDLE: ;
                S_START: begin
                    // The nibble on the first LFRAME#-high clock is already CYCTYPE+DIR
                    if (start_nib == 4'b0000 || start_nib == 4'b0101) begin
                        tpm_d = (start_nib == 4'b0101);
                        if (lpc_ad[3:2] == 2'b00) begin
                            dir_d   = lpc_ad[1];
                            cnt_d   = 2'd0;
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CYCDIR: begin
                    if (lpc_ad[3:2] == 2'b00) begin
                        dir_d   = lpc_ad[1];
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_d = {addr_q[11:0], lpc_ad};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = dir_q ? S_WDATA : S_TAR;
                    end
                end
                S_WDATA: begin
                    if (cnt_q == 2'd0) begin
                        data_d[3:0] = lpc_ad;
                        cnt_d       = 2'd1;
                    end else begin
                        data_d[7:4] = lpc_ad;
                        cnt_d       = 2'd0;
                        state_d     = S_TAR;
                    end
                end
                S_TAR: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d   = 2'd0;
                        wait_d  = '0;
                        state_d = S_SYNC;
                    end
                end
                S_SYNC: begin
                    case (lpc_ad)
                        4'b0000, 4'b1010: begin
                            err_d = (lpc_ad == 4'b1010);
                            if (dir_q) begin
                                emit    = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                cnt_d   = 2'd0;
                                state_d = S_RDATA;
                            end
                        end
                        4'b0101, 4'b0110: begin
                            if (wait_q == WAIT_LIM) begin
                                state_d = S_IDLE;
                            end else begin
                                wait_d = wait_q + WW'(1);
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_RDATA: begin
                    if (cnt_q == 2'd0) begin
                        data_d[3:0] = lpc_ad;
                        cnt_d       = 2'd1;
                    end else begin
                        data_d[7:4] = lpc_ad;
                        cnt_d       = 2'd0;
                        emit        = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb/tb_lpc_cycle_decoder.sv - scoreboard bench for lpc_cycle_decoder

module tb_lpc_cycle_decoder;

    localparam int SYNC_MAX = 4;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic        lpc_frame = 1'b1;
    logic [3:0]  lpc_ad    = 4'hF;
    logic        out_valid;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        out_dir;
    logic        out_tpm;
    logic        out_sync_err;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        dir;
        logic        tpm;
        logic        err;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   valid_cyc = 0;

    lpc_cycle_decoder #(.SYNC_MAX(SYNC_MAX)) dut (
        .lpc_clock    (lpc_clock),
        .lpc_reset    (lpc_reset),
        .lpc_frame    (lpc_frame),
        .lpc_ad       (lpc_ad),
        .out_valid    (out_valid),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_dir      (out_dir),
        .out_tpm      (out_tpm),
        .out_sync_err (out_sync_err)
    );

    always #15 lpc_clock = ~lpc_clock;

    always @(posedge lpc_clock) cyc <= cyc + 1;

    always @(negedge lpc_clock) begin : monitor
        rec_t got;
        rec_t want;
        if (out_valid) begin
            got = {out_addr, out_data, out_dir, out_tpm, out_sync_err};
            valid_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_record got addr=%h data=%h dir=%b tpm=%b err=%b",
                         got.addr, got.data, got.dir, got.tpm, got.err);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL record got addr=%h data=%h dir=%b tpm=%b err=%b want addr=%h data=%h dir=%b tpm=%b err=%b",
                             got.addr, got.data, got.dir, got.tpm, got.err,
                             want.addr, want.data, want.dir, want.tpm, want.err);
                end
            end
        end
    end

    task automatic drive(input logic f, input logic [3:0] ad);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad    = ad;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 4'hF);
    endtask

    // Model: a record appears only for a good start nibble, an I/O cycle type,
    // no more than SYNC_MAX waits and a ready/error SYNC terminator.
    task automatic do_cycle(input logic [3:0] st, input logic [3:0] cd, input logic [15:0] a,
                            input logic [7:0] d, input int waits, input logic [3:0] term);
        bit wr, ok, err;
        wr  = cd[1];
        err = (term == 4'hA);
        ok  = (st == 4'h0 || st == 4'h5) && (cd[3:2] == 2'b00) && (waits <= SYNC_MAX)
              && (term == 4'h0 || err);
        if (ok) exp_q.push_back({a, (err && !wr) ? 8'h00 : d, wr, st == 4'h5, err});
        drive(1'b0, st);
        start_cyc = cyc;
        drive(1'b1, cd);
        for (int i = 3; i >= 0; i--) drive(1'b1, a[i*4 +: 4]);
        if (wr) begin
            drive(1'b1, d[3:0]);
            drive(1'b1, d[7:4]);
        end
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        for (int i = 0; i < waits; i++) drive(1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6);
        drive(1'b1, term);
        if (!wr) begin
            drive(1'b1, d[3:0]);
            drive(1'b1, d[7:4]);
        end
    endtask

    logic [3:0] terms [6];
    logic [3:0] r_st, r_cd, r_tm;
    int         r_waits;

    initial begin
        terms = '{4'h0, 4'h0, 4'h0, 4'hA, 4'h3, 4'hF};
        repeat (3) @(negedge lpc_clock);
        total++;
        if ({out_valid, out_addr, out_data, out_dir, out_tpm, out_sync_err} !== 28'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0",
                     {out_valid, out_addr, out_data, out_dir, out_tpm, out_sync_err});
        end
        lpc_reset = 1'b1;
        idle(2);

        do_cycle(4'h0, 4'b0010, 16'h0080, 8'h5A, 0, 4'h0);
        idle(3);
        total++;
        if (valid_cyc - start_cyc != 11) begin
            bad++;
            $display("FAIL write_latency got=%0d want=11", valid_cyc - start_cyc);
        end

        do_cycle(4'h5, 4'b0000, 16'h0F00, 8'h81, 3, 4'h0);

        drive(1'b0, 4'h0);
        drive(1'b1, 4'b0010);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        do_cycle(4'h0, 4'b0010, 16'h002E, 8'h11, 0, 4'h0);

        do_cycle(4'h5, 4'b0010, 16'h1234, 8'h77, 5, 4'h0);
        do_cycle(4'h0, 4'b0000, 16'h0060, 8'h3C, SYNC_MAX, 4'h0);

        do_cycle(4'h0, 4'b0100, 16'h4444, 8'h44, 0, 4'h0);
        do_cycle(4'hF, 4'b0010, 16'h5555, 8'h55, 0, 4'h0);
        do_cycle(4'h0, 4'b0010, 16'h0378, 8'hC3, 1, 4'hA);
        do_cycle(4'h5, 4'b0000, 16'h0F24, 8'h9E, 0, 4'hA);

        drive(1'b0, 4'h3);
        do_cycle(4'h0, 4'b0010, 16'hBEEF, 8'hA5, 0, 4'h0);
        do_cycle(4'h0, 4'b0000, 16'h0070, 8'h12, 2, 4'h3);

        idle(2);
        drive(1'b0, 4'h0);
        drive(1'b1, 4'b0010);
        drive(1'b1, 4'h1);
        #3 lpc_reset = 1'b0;
        #1;
        total++;
        if ({out_valid, out_addr, out_data, out_dir, out_tpm, out_sync_err} !== 28'd0) begin
            bad++;
            $display("FAIL reset_mid_addr got=%h want=0",
                     {out_valid, out_addr, out_data, out_dir, out_tpm, out_sync_err});
        end
        lpc_frame = 1'b1;
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        idle(1);
        do_cycle(4'h0, 4'b0010, 16'h0CF9, 8'h06, 0, 4'h0);

        for (int n = 0; n < 40; n++) begin
            r_st = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                 : (($urandom_range(0, 1) != 0) ? 4'h5 : 4'h0);
            r_cd = ($urandom_range(0, 7) == 0) ? 4'($urandom) : {2'b00, 2'($urandom)};
            r_tm = terms[$urandom_range(0, 5)];
            r_waits = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) drive(1'b0, 4'($urandom));
            do_cycle(r_st, r_cd, 16'($urandom), 8'($urandom), r_waits, r_tm);
            idle($urandom_range(0, 2));
        end

        idle(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_records got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
